// File: rtl/intdiv_iter.sv
// Iterative radix-2 restoring divider for RV M-extension div/rem (and W forms).
// Build option: define IDIV_EARLY_TERM_EN to skip leading-zero iterations.
module intdiv_iter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            IntDivE,
   input  logic [2:0]      Funct3E,
   input  logic            W64E,
   input  logic [XLEN-1:0] ForwardedSrcAE,
   input  logic [XLEN-1:0] ForwardedSrcBE,
   input  logic            StallE,
   input  logic            FlushE,
   output logic            DivBusyE,
   output logic            DivDoneE,
   output logic [XLEN-1:0] DivResultE
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MINX = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

   stateT state, nextState;

   logic [XLEN-1:0] remR, quotR, divR;
   logic [CW-1:0]   cntR;
   logic            isRemR, negQR, negRR, isWR;

   logic            start, isW, isSigned, isRem;
   logic [XLEN-1:0] opA, opB, magA, magB, minN;
   logic            sA, sB, divZero, overflow, special;
   logic [XLEN-1:0] specialRaw, specialRes;
   logic [CW-1:0]   nBits, baseSh, shamt, cnt0;

   logic [XLEN:0]   remSh, diff;
   logic            ge;
   logic [XLEN-1:0] remNext, quotNext, val, fixed, finalRes;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

`ifdef IDIV_EARLY_TERM_EN
   logic [CW-1:0] lzRaw, lz, iters;

   function automatic logic [CW-1:0] lzc(input logic [XLEN-1:0] v);
      lzc = CW'(XLEN);
      for (int i = 0; i < XLEN; i++)
         if (v[i]) lzc = CW'(XLEN - 1 - i);
   endfunction
`endif

   assign start = IntDivE & ~FlushE;
   assign isW   = (XLEN == 64) && W64E;

   always_comb begin
      isSigned = 1'b0;
      isRem    = 1'b0;
      case (Funct3E)
         3'b100:  begin isSigned = 1'b1; isRem = 1'b0; end
         3'b101:  begin isSigned = 1'b0; isRem = 1'b0; end
         3'b110:  begin isSigned = 1'b1; isRem = 1'b1; end
         3'b111:  begin isSigned = 1'b0; isRem = 1'b1; end
         default: begin isSigned = 1'b0; isRem = 1'b0; end
      endcase
   end

   // W ops work on the low word, extended so the XLEN datapath sees its value
   always_comb begin
      opA = ForwardedSrcAE;
      opB = ForwardedSrcBE;
      if (isW) begin
         opA = isSigned ? sext32(ForwardedSrcAE[31:0])
                        : XLEN'(ForwardedSrcAE[31:0]);
         opB = isSigned ? sext32(ForwardedSrcBE[31:0])
                        : XLEN'(ForwardedSrcBE[31:0]);
      end
   end

   assign sA   = isSigned & opA[XLEN-1];
   assign sB   = isSigned & opB[XLEN-1];
   assign magA = sA ? -opA : opA;
   assign magB = sB ? -opB : opB;

   assign minN     = isW ? sext32(32'h8000_0000) : MINX;
   assign divZero  = (opB == '0);
   assign overflow = isSigned & (opA == minN) & (opB == '1);
   assign special  = divZero | overflow;

   always_comb begin
      if (divZero)
         specialRaw = isRem ? opA : '1;
      else
         specialRaw = isRem ? '0 : opA;
      specialRes = isW ? sext32(specialRaw[31:0]) : specialRaw;
   end

   assign nBits  = isW ? CW'(32) : CW'(XLEN);
   assign baseSh = CW'(XLEN) - nBits;

`ifdef IDIV_EARLY_TERM_EN
   assign lzRaw = lzc(magA << baseSh);
   assign lz    = (lzRaw > nBits) ? nBits : lzRaw;
   assign iters = nBits - lz;
   assign shamt = baseSh + lz;
   assign cnt0  = (iters == '0) ? '0 : iters - CW'(1);
`else
   assign shamt = baseSh;
   assign cnt0  = nBits - CW'(1);
`endif

   // Dividend bits leave quotR from the top while quotient bits enter below
   assign remSh    = {remR, quotR[XLEN-1]};
   assign diff     = remSh - {1'b0, divR};
   assign ge       = ~diff[XLEN];
   assign remNext  = ge ? diff[XLEN-1:0] : remSh[XLEN-1:0];
   assign quotNext = {quotR[XLEN-2:0], ge};

   always_comb begin
      val      = isRemR ? remNext : quotNext;
      fixed    = (isRemR ? negRR : negQR) ? -val : val;
      finalRes = isWR ? sext32(fixed[31:0]) : fixed;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (start) nextState = special ? DONE : BUSY;
         BUSY: begin
            if (FlushE)          nextState = IDLE;
            else if (cntR == '0) nextState = DONE;
         end
         DONE: if (!StallE || FlushE) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      DivBusyE = reset & (((state == IDLE) & start) | (state == BUSY));
      DivDoneE = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remR       <= '0;
         quotR      <= '0;
         divR       <= '0;
         cntR       <= '0;
         isRemR     <= 1'b0;
         negQR      <= 1'b0;
         negRR      <= 1'b0;
         isWR       <= 1'b0;
         DivResultE <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && special) begin
                  DivResultE <= specialRes;
               end else if (start) begin
                  remR   <= '0;
                  quotR  <= magA << shamt;
                  divR   <= magB;
                  cntR   <= cnt0;
                  isRemR <= isRem;
                  negQR  <= sA ^ sB;
                  negRR  <= sA;
                  isWR   <= isW;
               end
            end
            BUSY: begin
               if (!FlushE) begin
                  remR  <= remNext;
                  quotR <= quotNext;
                  if (cntR == '0) DivResultE <= finalRes;
                  else            cntR       <= cntR - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_intdiv_iter.sv
// Directed bench for intdiv_iter (XLEN=64): results, latency, flush, stall, reset.
module tb_intdiv_iter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        IntDivE = 1'b0;
   logic [2:0]  Funct3E = 3'b000;
   logic        W64E = 1'b0;
   logic [63:0] srcA = '0;
   logic [63:0] srcB = '0;
   logic        StallE = 1'b0;
   logic        FlushE = 1'b0;
   logic        busy, done;
   logic [63:0] res;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] lastRes = '0;

`ifdef IDIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   intdiv_iter #(.XLEN(64)) dut (
      .clk(clk),
      .reset(reset),
      .IntDivE(IntDivE),
      .Funct3E(Funct3E),
      .W64E(W64E),
      .ForwardedSrcAE(srcA),
      .ForwardedSrcBE(srcB),
      .StallE(StallE),
      .FlushE(FlushE),
      .DivBusyE(busy),
      .DivDoneE(done),
      .DivResultE(res)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Expected cycles from the start cycle to the first DivDoneE cycle
   function automatic int expLat(input int n, input logic [63:0] mag);
      int lz;
      int it;
      lz = n;
      for (int i = 0; i < n; i++)
         if (mag[i]) lz = n - 1 - i;
      it = (n - lz > 1) ? n - lz : 1;
      return EARLY ? it + 1 : n + 1;
   endfunction

   task automatic startOp(input string tag, input logic [2:0] f3,
                          input logic w, input logic [63:0] a,
                          input logic [63:0] b);
      @(negedge clk);
      Funct3E = f3;
      W64E    = w;
      srcA    = a;
      srcB    = b;
      IntDivE = 1'b1;
      #1 checkVal({tag, "/busyAtStart"}, 64'(busy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      IntDivE = 1'b0;
   endtask

   task automatic waitDone(input string tag, output int lat);
      lat = 1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!done) checkVal({tag, "/timeout"}, 64'(done), 64'd1);
   endtask

   task automatic runDiv(input string tag, input logic [2:0] f3,
                         input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp,
                         input int expL);
      int lat;
      startOp(tag, f3, w, a, b);
      waitDone(tag, lat);
      checkVal({tag, "/res"}, res, exp);
      checkVal({tag, "/lat"}, 64'(lat), 64'(expL));
      lastRes = exp;
      @(negedge clk);
      checkVal({tag, "/idleAfter"}, 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      int seen;

      #2;
      IntDivE = 1'b1;
      Funct3E = 3'b101;
      srcA    = 64'd100;
      srcB    = 64'd7;
      @(negedge clk);
      checkVal("reset/busy", 64'(busy), 64'd0);
      checkVal("reset/done", 64'(done), 64'd0);
      checkVal("reset/res", res, 64'd0);
      IntDivE = 1'b0;
      reset   = 1'b1;

      runDiv("divu100_7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14,
             expLat(64, 64'd100));
      runDiv("remu100_7", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2,
             expLat(64, 64'd100));
      runDiv("div-7_2", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFD, expLat(64, 64'd7));
      runDiv("rem-7_2", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, expLat(64, 64'd7));
      runDiv("rem7_-2", 3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
             64'd1, expLat(64, 64'd7));
      runDiv("divu5_0", 3'b101, 1'b0, 64'd5, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 1);
      runDiv("remu5_0", 3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1);
      runDiv("div0_0", 3'b100, 1'b0, 64'd0, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 1);
      runDiv("divMin_-1", 3'b100, 1'b0, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      runDiv("remMin_-1", 3'b110, 1'b0, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      runDiv("divuw", 3'b101, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd1,
             64'hFFFF_FFFF_FFFF_FFFE, expLat(32, 64'hFFFF_FFFE));
      runDiv("divwOvf", 3'b100, 1'b1, 64'h0000_0000_8000_0000,
             64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      runDiv("divw-7_2", 3'b100, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFD, expLat(32, 64'd7));
      runDiv("remuw", 3'b111, 1'b1, 64'h1234_5678_0000_0064, 64'd7,
             64'd2, expLat(32, 64'd100));

      startOp("flush", 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      repeat (9) @(negedge clk);
      FlushE = 1'b1;
      @(negedge clk);
      FlushE = 1'b0;
      checkVal("flush/busy", 64'(busy), 64'd0);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      checkVal("flush/noDone", 64'(seen), 64'd0);
      checkVal("flush/keepRes", res, lastRes);
      runDiv("divu9_3", 3'b101, 1'b0, 64'd9, 64'd3, 64'd3,
             expLat(64, 64'd9));

      StallE = 1'b1;
      startOp("stall", 3'b101, 1'b0, 64'd1000, 64'd10);
      waitDone("stall", lat);
      checkVal("stall/res", res, 64'd100);
      checkVal("stall/lat", 64'(lat), 64'(expLat(64, 64'd1000)));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkVal($sformatf("stall/holdDone%0d", i), 64'(done), 64'd1);
         checkVal($sformatf("stall/holdRes%0d", i), res, 64'd100);
      end
      StallE = 1'b0;
      @(negedge clk);
      checkVal("stall/release", 64'(done), 64'd0);

      startOp("midReset", 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      checkVal("midReset/busy", 64'(busy), 64'd0);
      checkVal("midReset/done", 64'(done), 64'd0);
      checkVal("midReset/res", res, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      runDiv("afterReset", 3'b101, 1'b0, 64'd21, 64'd4, 64'd5,
             expLat(64, 64'd21));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
